// File: rtl/interval_arbiter_pkg.sv
// Shared types, default sizes and the round-robin pick helper for interval_arbiter.
package interval_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int MAX_REQ     = 8;
  localparam int MAX_IDW     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  // Search starts one past the last winner and wraps modulo num_req; the
  // request vector is zero-extended to MAX_REQ so one function serves all sizes.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req_vec,
                                       input logic [MAX_IDW-1:0] last_idx,
                                       input int                 num_req);
    rr_pick_t           res;
    int                 cand;
    logic [MAX_IDW-1:0] cand_idx;
    res = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      cand     = (int'(last_idx) + k) % num_req;
      cand_idx = cand[MAX_IDW-1:0];
      if ((k <= num_req) && !res.valid && req_vec[cand_idx]) begin
        res.valid = 1'b1;
        res.idx   = cand_idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/interval_arbiter_up_counter.sv
// Shared interval counter: synchronous active-low reset, clear beats enable.
module up_counter import interval_arbiter_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] q
);

  // Counter register: reset, then clear, then count up when enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= {WIDTH{1'b0}};
    end else if (clear) begin
      q <= {WIDTH{1'b0}};
    end else if (enable) begin
      q <= q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/interval_arbiter.sv
// Round-robin arbiter that lends one up-counter to a requester for a timed
// interval, pulsing done when the latched length has been counted out.
module interval_arbiter import interval_arbiter_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] len,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [WIDTH-1:0]         count,
  output logic                     done,
  output logic [IDW-1:0]           done_id
);

  state_e               state_q, state_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [IDW-1:0]       last_id_q, last_id_d;
  logic [WIDTH-1:0]     target_q, target_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [IDW-1:0]       done_id_q, done_id_d;

  logic [MAX_REQ-1:0]   req_ext_s;
  rr_pick_t             pick_s;
  logic [IDW-1:0]       winner_s;
  logic                 pick_unused_s;
  logic                 cnt_clear_s;
  logic                 cnt_en_s;
  logic [WIDTH-1:0]     count_s;

  assign req_ext_s     = MAX_REQ'(req);
  assign pick_s        = rr_pick(req_ext_s, MAX_IDW'(last_id_q), NUM_REQ);
  assign winner_s      = pick_s.idx[IDW-1:0];
  assign pick_unused_s = ^pick_s.idx;

  up_counter #(.WIDTH(WIDTH)) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear_s),
    .enable (cnt_en_s),
    .q      (count_s)
  );

  // Next-state, latch and counter-control logic; abort outranks target match.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_id_d   = last_id_q;
    target_d    = target_q;
    grant_d     = grant_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    cnt_clear_s = 1'b0;
    cnt_en_s    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clear_s = 1'b1;
        grant_d     = {NUM_REQ{1'b0}};
        if (pick_s.valid) begin
          state_d   = RUN;
          owner_d   = winner_s;
          last_id_d = winner_s;
          target_d  = len[winner_s*WIDTH +: WIDTH];
          grant_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
        end else begin
          state_d   = IDLE;
        end
      end
      RUN: begin
        if (!req[owner_q]) begin
          state_d     = IDLE;
          grant_d     = {NUM_REQ{1'b0}};
          cnt_clear_s = 1'b1;
        end else if (count_s == target_q) begin
          state_d   = DONE;
          grant_d   = {NUM_REQ{1'b0}};
          done_d    = 1'b1;
          done_id_d = owner_q;
        end else begin
          cnt_en_s  = 1'b1;
        end
      end
      DONE: begin
        state_d     = IDLE;
        grant_d     = {NUM_REQ{1'b0}};
        cnt_clear_s = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        grant_d     = {NUM_REQ{1'b0}};
        cnt_clear_s = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, pointer and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= {IDW{1'b0}};
      last_id_q <= IDW'(NUM_REQ - 1);
      target_q  <= {WIDTH{1'b0}};
      grant_q   <= {NUM_REQ{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= {IDW{1'b0}};
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_id_q <= last_id_d;
      target_q  <= target_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign count   = count_s;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule
